// File: rtl/spi_master_transmit_only_if.sv
// Frame request/serial-output bundle for spi_master_transmit_only.
// master: the transmitter side. slave: the requester/monitor side.
interface spi_master_transmit_only_if;
  logic        valid;
  logic [15:0] xpos;
  logic [15:0] ypos;
  logic        ready;
  logic        busy;
  logic        done;
  logic        sck;
  logic        sdo;

  modport master (input valid, xpos, ypos, output ready, busy, done, sck, sdo);
  modport slave  (output valid, xpos, ypos, input ready, busy, done, sck, sdo);
endinterface

// File: rtl/spi_master_transmit_only.sv
// Chip-select-less SPI transmitter: serialises {xpos,ypos} MSB first, sdo changes on sck rise.
// Optional macro SPI_TX_FLUSH_EN adds one trailing sck pulse (sdo=0) after each frame.
module spi_master_transmit_only #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  spi_master_transmit_only_if.master    bus
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef SPI_TX_FLUSH_EN
  typedef enum logic [2:0] {IDLE, HIGH, LOW, GAP, FLUSH} state_t;
`else
  typedef enum logic [2:0] {IDLE, HIGH, LOW, GAP} state_t;
`endif

  state_t        state, state_n;
  logic [31:0]   shreg, shreg_n;     // bit 31 is always the next bit to send
  logic [4:0]    bitcnt, bitcnt_n;
  logic [DW-1:0] divcnt, divcnt_n;
  logic [GW-1:0] gapcnt, gapcnt_n;
  logic          sck_q, sck_n;
  logic          sdo_q, sdo_n;
  logic          done_q, done_n;
  logic          enter_tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      divcnt <= '0;
      gapcnt <= '0;
      sck_q  <= 1'b0;
      sdo_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      bitcnt <= bitcnt_n;
      divcnt <= divcnt_n;
      gapcnt <= gapcnt_n;
      sck_q  <= sck_n;
      sdo_q  <= sdo_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bitcnt_n   = bitcnt;
    divcnt_n   = divcnt;
    gapcnt_n   = gapcnt;
    sck_n      = sck_q;
    sdo_n      = sdo_q;
    done_n     = 1'b0;
    enter_tail = 1'b0;

    case (state)
      IDLE: begin
        if (bus.valid) begin
          shreg_n  = {bus.xpos[14:0], bus.ypos, 1'b0};
          sdo_n    = bus.xpos[15];
          sck_n    = 1'b1;
          bitcnt_n = 5'd31;
          divcnt_n = '0;
          state_n  = HIGH;
        end
      end
      HIGH: begin
        if (divcnt == DIV_LAST) begin
          divcnt_n = '0;
          sck_n    = 1'b0;
          state_n  = LOW;
        end else begin
          divcnt_n = divcnt + DW'(1);
        end
      end
      LOW: begin
        if (divcnt == DIV_LAST) begin
          divcnt_n = '0;
          if (bitcnt != 5'd0) begin
            bitcnt_n = bitcnt - 5'd1;
            sdo_n    = shreg[31];
            shreg_n  = {shreg[30:0], 1'b0};
            sck_n    = 1'b1;
            state_n  = HIGH;
          end else begin
`ifdef SPI_TX_FLUSH_EN
            sck_n   = 1'b1;
            sdo_n   = 1'b0;
            state_n = FLUSH;
`else
            enter_tail = 1'b1;
`endif
          end
        end else begin
          divcnt_n = divcnt + DW'(1);
        end
      end
`ifdef SPI_TX_FLUSH_EN
      // sck itself tells which half of the flush pulse is running.
      FLUSH: begin
        if (divcnt == DIV_LAST) begin
          divcnt_n = '0;
          if (sck_q) sck_n = 1'b0;
          else       enter_tail = 1'b1;
        end else begin
          divcnt_n = divcnt + DW'(1);
        end
      end
`endif
      GAP: begin
        if (gapcnt == GAP_LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          gapcnt_n = gapcnt + GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Frame tail: quiet the line, then gap (or straight to IDLE with no gap).
    if (enter_tail) begin
      sck_n    = 1'b0;
      sdo_n    = 1'b0;
      gapcnt_n = '0;
      if (GAP_CYCLES == 0) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end else begin
        state_n = GAP;
      end
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q;
  assign bus.sck   = sck_q;
  assign bus.sdo   = sdo_q;

endmodule
